// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, matrix size,
// idle column pattern, key encoding and column drive decoding.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam logic [KP_COLS-1:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_e;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] idx);
    logic [KP_COLS-1:0] drv;
    case (idx)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = COL_IDLE;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the keypad row inputs; idles high (no key) in reset.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] async_i,
  output logic [KP_ROWS-1:0] sync_o
);

  logic [KP_ROWS-1:0] meta_q;
  logic [KP_ROWS-1:0] sync_q;

  // Two-stage capture of the asynchronous row pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {KP_ROWS{1'b1}};
      sync_q <= {KP_ROWS{1'b1}};
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: column scan, press/release debounce, key code and strobe.
// Optional auto-repeat of key_strobe while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] fila,
  output logic [KP_COLS-1:0] col,
  output logic [3:0]         posicion,
  output logic               opr,
  output logic               key_strobe
);

  localparam int MAX_SD  = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int MAX_REP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_ALL = (MAX_SD > MAX_REP) ? MAX_SD : MAX_REP;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
  // Reloading here makes the next strobe land exactly REPEAT_PERIOD cycles later
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  logic [KP_ROWS-1:0] frow;
  kp_state_e          state_q;
  logic [1:0]         col_idx_q;
  logic [KP_COLS-1:0] col_q;
  logic [CNT_W-1:0]   div_q;
  logic [CNT_W-1:0]   deb_q;
  logic [1:0]         cand_row_q;
  logic [1:0]         cand_col_q;
  logic [3:0]         posicion_q;
  logic               opr_q;
  logic               strobe_q;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]   rep_q;
`endif

  logic               row_hit_d;
  logic [1:0]         hit_row_d;
  logic               cand_high_d;
  logic [1:0]         next_col_d;

  keypad_row_sync u_row_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (fila),
    .sync_o  (frow)
  );

  // Lowest-index low row wins; also the tracked row level and next column
  always_comb begin
    row_hit_d = 1'b1;
    hit_row_d = 2'd0;
    casez (frow)
      4'b???0: hit_row_d = 2'd0;
      4'b??01: hit_row_d = 2'd1;
      4'b?011: hit_row_d = 2'd2;
      4'b0111: hit_row_d = 2'd3;
      default: row_hit_d = 1'b0;
    endcase
    cand_high_d = frow[cand_row_q];
    next_col_d  = col_idx_q + 2'd1;
  end

  // Scan / debounce FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      col_q      <= COL_IDLE;
      div_q      <= CNT_ZERO;
      deb_q      <= CNT_ZERO;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      posicion_q <= 4'd0;
      opr_q      <= 1'b0;
      strobe_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= CNT_ZERO;
`endif
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            div_q <= CNT_ZERO;
            if (row_hit_d) begin
              cand_row_q <= hit_row_d;
              cand_col_q <= col_idx_q;
              deb_q      <= CNT_ZERO;
              state_q    <= DEB_PRESS;
            end else begin
              col_idx_q <= next_col_d;
              col_q     <= col_drive(next_col_d);
            end
          end else begin
            div_q <= div_q + CNT_ONE;
          end
        end
        DEB_PRESS: begin
          if (cand_high_d) begin
            state_q   <= SCAN;
            div_q     <= CNT_ZERO;
            col_idx_q <= next_col_d;
            col_q     <= col_drive(next_col_d);
          end else if (deb_q == DEB_LAST) begin
            posicion_q <= key_code(cand_row_q, cand_col_q);
            opr_q      <= 1'b1;
            strobe_q   <= 1'b1;
            state_q    <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= CNT_ZERO;
`endif
          end else begin
            deb_q <= deb_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (cand_high_d) begin
            state_q <= DEB_REL;
            deb_q   <= CNT_ZERO;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= CNT_ZERO;
          end else if (rep_q == REP_LAST) begin
            strobe_q <= 1'b1;
            rep_q    <= REP_RELOAD;
          end else begin
            rep_q <= rep_q + CNT_ONE;
`endif
          end
        end
        DEB_REL: begin
          if (!cand_high_d) begin
            state_q <= PRESSED;
          end else if (deb_q == DEB_LAST) begin
            opr_q     <= 1'b0;
            state_q   <= SCAN;
            div_q     <= CNT_ZERO;
            col_idx_q <= next_col_d;
            col_q     <= col_drive(next_col_d);
          end else begin
            deb_q <= deb_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= SCAN;
          div_q     <= CNT_ZERO;
          col_idx_q <= 2'd0;
          col_q     <= COL_IDLE;
          opr_q     <= 1'b0;
        end
      endcase
    end
  end

  assign col        = col_q;
  assign posicion   = posicion_q;
  assign opr        = opr_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a keypad matrix model and a strobe scoreboard.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE_CYC  = 8;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 6;
  // column change -> sample at +SCAN_DIV, accept DEBOUNCE_CYC later
  localparam int ACC_LAT = SCAN_DIV + DEBOUNCE_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic [3:0]  posicion;
  logic        opr;
  logic        key_strobe;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    fila = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col[c]) fila[r] = 1'b0;
  end

  keypad_scan_debounce #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fila       (fila),
    .col        (col),
    .posicion   (posicion),
    .opr        (opr),
    .key_strobe (key_strobe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_col_enter(input logic [3:0] target, output int at);
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = col;
    at = cyc;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (col == target && prev != target) begin
        ok = 1'b1;
        at = cyc;
      end
      prev = col;
    end
    chk("col_enter", 32'(ok), 32'd1);
  endtask

  // Press keys so they become visible as the scan enters target column; check accept timing
  task automatic accept(input logic [15:0] mask, input logic [3:0] target,
                        input logic [3:0] code, output int a);
    int e;
    for (int i = 0; i < 32 && col == target; i++) @(negedge clk);
    keys = mask;
    wait_col_enter(target, e);
    a = e + ACC_LAT;
    exp_q.push_back('{code: code, at: a});
    wait_until(a - 1);
    chk("opr_before_accept", opr, 1'b0);
    wait_until(a);
    chk("opr_at_accept", opr, 1'b1);
    chk("posicion_at_accept", posicion, code);
  endtask

  task automatic release_key(input logic [3:0] code);
    int r;
    r = cyc;
    keys = 16'h0000;
    wait_until(r + 2 + DEBOUNCE_CYC);
    chk("opr_before_release", opr, 1'b1);
    wait_until(r + 3 + DEBOUNCE_CYC);
    chk("opr_released", opr, 1'b0);
    chk("posicion_held", posicion, code);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && key_strobe) begin
      exp_t e;
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_code", posicion, e.code);
        chk("strobe_cycle", cyc, e.at);
        chk("strobe_with_opr", opr, 1'b1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int e;
    int k;
    rst  = 1'b1;
    keys = 16'h0000;
    @(negedge clk);
    chk("reset_col", col, 4'b1110);
    chk("reset_opr", opr, 1'b0);
    chk("reset_posicion", posicion, 4'd0);
    chk("reset_strobe", key_strobe, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Key 9 (row2, col1): clean press, release glitch, final release
    accept(16'h0200, 4'b1101, 4'd9, a);
    @(negedge clk);
    chk("strobe_one_cycle", key_strobe, 1'b0);
    k = cyc;
    keys = 16'h0000;
    wait_until(k + 2);
    keys = 16'h0200;
    wait_until(k + 15);
    chk("opr_through_glitch", opr, 1'b1);
    release_key(4'd9);
    chk("col_after_release", col, 4'b1011);

    // Key 0 bounces during press debounce: abort and resume scanning
    for (int i = 0; i < 32 && col == 4'b1110; i++) @(negedge clk);
    keys = 16'h0001;
    wait_col_enter(4'b1110, e);
    wait_until(e + SCAN_DIV + 1);
    keys = 16'h0000;
    wait_until(e + SCAN_DIV + 3);
    chk("col_frozen", col, 4'b1110);
    wait_until(e + SCAN_DIV + 4);
    chk("col_after_abort", col, 4'b1101);
    chk("opr_after_abort", opr, 1'b0);
    wait_until(e + 2*SCAN_DIV + 4);
    chk("col_resumed", col, 4'b1011);
    chk("posicion_kept", posicion, 4'd9);

    // Rows 1 and 3 on col3 together: lowest row wins
    accept(16'h8080, 4'b0111, 4'd7, a);
    release_key(4'd7);
    accept(16'h0001, 4'b1110, 4'd0, a);
    release_key(4'd0);

    // Long hold of key 5: auto-repeat strobes only when enabled
    accept(16'h0020, 4'b1101, 4'd5, a);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back('{code: 4'd5, at: a + 20});
    exp_q.push_back('{code: 4'd5, at: a + 26});
    exp_q.push_back('{code: 4'd5, at: a + 32});
    exp_q.push_back('{code: 4'd5, at: a + 38});
`endif
    wait_until(a + 40);
    release_key(4'd5);

    // Asynchronous reset while a key is held
    accept(16'h0200, 4'b1101, 4'd9, a);
    wait_until(a + 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_opr", opr, 1'b0);
    chk("rst_posicion", posicion, 4'd0);
    chk("rst_strobe", key_strobe, 1'b0);
    keys = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    e = cyc;
    wait_until(e + SCAN_DIV - 1);
    chk("scan_dwell_after_rst", col, 4'b1110);
    wait_until(e + SCAN_DIV);
    chk("scan_resumed_after_rst", col, 4'b1101);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
